// File: rtl/block_xfer_seq.sv
// block_xfer_seq: LDM/STM block-transfer sequencer walking a register list in ascending order.
// Define BLOCK_XFER_WRITEBACK_EN to add the base-register writeback state.
module block_xfer_seq #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              is_load,
   input  logic              up,
   input  logic              pre,
   input  logic              writeback,
   input  logic [3:0]        base_reg,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       reg_list,
   input  logic [DATA_W-1:0] rb_read_data,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic [3:0]        rb_read_select,
   output logic              rb_write_en,
   output logic [3:0]        rb_write_select,
   output logic [DATA_W-1:0] rb_write_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_NEXT  = 3'd2;
   localparam logic [2:0] S_RDREG = 3'd3;
   localparam logic [2:0] S_BEAT  = 3'd4;
   localparam logic [2:0] S_WB    = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

   logic [2:0]        state_q, state_d;
   logic              load_q, load_d;
   logic              up_q, up_d;
   logic              pre_q, pre_d;
   logic [15:0]       list_q, list_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        cur_q, cur_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              first_q, first_d;
   logic [ADDR_W-1:0] span;
   logic [2:0]        fin;
   logic              beat;
   logic              ld_wr;
   logic              unused_bits;

   function automatic logic [3:0] low_idx(input logic [15:0] l);
      low_idx = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (l[i]) low_idx = 4'(i);
   endfunction

   assign span = ADDR_W'({5'($countones(list_q)), 2'b00});

`ifdef BLOCK_XFER_WRITEBACK_EN
   logic              wb_q, wb_d;
   logic [3:0]        base_reg_q, base_reg_d;
   logic [ADDR_W-1:0] final_q, final_d;
   assign fin = wb_q ? S_WB : S_DONE;
   assign unused_bits = ^base_addr[1:0];
`else
   assign fin = S_DONE;
   assign unused_bits = ^{base_addr[1:0], writeback, base_reg};
`endif

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      up_d    = up_q;
      pre_d   = pre_q;
      list_d  = list_q;
      addr_d  = addr_q;
      cur_d   = cur_q;
      wdata_d = wdata_q;
      first_d = first_q;
`ifdef BLOCK_XFER_WRITEBACK_EN
      wb_d       = wb_q;
      base_reg_d = base_reg_q;
      final_d    = final_q;
`endif
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_SETUP;
            load_d  = is_load;
            up_d    = up;
            pre_d   = pre;
            list_d  = reg_list;
            addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
`ifdef BLOCK_XFER_WRITEBACK_EN
            // a loaded base register takes priority over the writeback value
            wb_d       = writeback & ~(is_load & reg_list[base_reg]);
            base_reg_d = base_reg;
`endif
         end
         S_SETUP: begin
            addr_d  = up_q ? addr_q + (pre_q ? WORD : '0) : addr_q - span + (pre_q ? '0 : WORD);
`ifdef BLOCK_XFER_WRITEBACK_EN
            final_d = up_q ? addr_q + span : addr_q - span;
`endif
            state_d = (list_q == 16'd0) ? S_DONE : S_NEXT;
         end
         S_NEXT: if (list_q == 16'd0) state_d = fin;
         else begin
            cur_d   = low_idx(list_q);
            list_d  = list_q & (list_q - 16'd1);
            first_d = 1'b1;
            state_d = load_q ? S_BEAT : S_RDREG;
         end
         S_RDREG: state_d = S_BEAT;
         S_BEAT: begin
            first_d = 1'b0;
            if (first_q) wdata_d = rb_read_data;
            if (mem_ack) begin
               addr_d  = addr_q + WORD;
               state_d = (list_q == 16'd0) ? fin : S_NEXT;
            end
         end
         S_WB:    state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         load_q  <= 1'b0;
         up_q    <= 1'b0;
         pre_q   <= 1'b0;
         list_q  <= '0;
         addr_q  <= '0;
         cur_q   <= '0;
         wdata_q <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         up_q    <= up_d;
         pre_q   <= pre_d;
         list_q  <= list_d;
         addr_q  <= addr_d;
         cur_q   <= cur_d;
         wdata_q <= wdata_d;
         first_q <= first_d;
      end
   end

`ifdef BLOCK_XFER_WRITEBACK_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wb_q       <= 1'b0;
         base_reg_q <= '0;
         final_q    <= '0;
      end else begin
         wb_q       <= wb_d;
         base_reg_q <= base_reg_d;
         final_q    <= final_d;
      end
   end
`endif

   assign beat  = state_q == S_BEAT;
   assign ld_wr = beat & load_q & mem_ack & reset_n;

   always_comb begin
      busy           = state_q != S_IDLE;
      done           = state_q == S_DONE;
      rb_read_select = (state_q == S_RDREG) ? cur_q : 4'd0;
      mem_req        = beat;
      mem_we         = beat & ~load_q;
      mem_addr       = beat ? addr_q : '0;
      // bank data arrives one cycle after the select, so the first beat cycle forwards it
      mem_wdata      = (beat & ~load_q) ? (first_q ? rb_read_data : wdata_q) : '0;
`ifdef BLOCK_XFER_WRITEBACK_EN
      rb_write_en     = ld_wr | (state_q == S_WB);
      rb_write_select = (state_q == S_WB) ? base_reg_q : ld_wr ? cur_q : 4'd0;
      rb_write_data   = (state_q == S_WB) ? DATA_W'(final_q) : ld_wr ? mem_rdata : '0;
`else
      rb_write_en     = ld_wr;
      rb_write_select = ld_wr ? cur_q : 4'd0;
      rb_write_data   = ld_wr ? mem_rdata : '0;
`endif
   end
endmodule

// File: tb/tb_block_xfer_seq.sv
// tb_block_xfer_seq: random and directed block transfers checked against a list-level reference model.
module tb_block_xfer_seq;
   logic        clk = 0, reset_n = 0, start = 0, is_load = 0, up = 0, pre = 0, writeback = 0;
   logic [3:0]  base_reg = 0;
   logic [31:0] base_addr = 0, rb_read_data = 0, mem_rdata = 0;
   logic [15:0] reg_list = 0;
   logic        mem_ack = 0;
   logic        busy, done, rb_write_en, mem_req, mem_we;
   logic [3:0]  rb_read_select, rb_write_select;
   logic [31:0] rb_write_data, mem_addr, mem_wdata;

   block_xfer_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load), .up(up), .pre(pre),
      .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
      .rb_read_data(rb_read_data), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy),
      .done(done), .rb_read_select(rb_read_select), .rb_write_en(rb_write_en),
      .rb_write_select(rb_write_select), .rb_write_data(rb_write_data), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   logic [31:0] regs [16];
   logic [31:0] mem [1024];
   logic        pend_we = 0;
   logic [3:0]  pend_wsel = 0, pend_rsel = 0;
   logic [31:0] pend_wdata = 0;
   int          waits [16];
   int          wait_cnt = 0, beat_no = 0, cyc = 0, nob = 0, nwr = 0;
   logic        beat_active = 0, prev_ack = 0, done_seen = 0, hold_we = 0;
   logic [31:0] hold_addr = 0, hold_wdata = 0;
   logic [31:0] ob_addr [32], ob_data [32];
   logic        ob_we [32];
   logic [3:0]  ow_sel [32];
   logic [31:0] ow_data [32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock: bank and memory respond after the edge, then outputs are observed
   task automatic step();
      @(posedge clk); #1;
      rb_read_data = regs[pend_rsel];
      if (pend_we) regs[pend_wsel] = pend_wdata;
      if (mem_req && wait_cnt >= waits[beat_no & 15]) begin
         mem_ack = 1; mem_rdata = mem[mem_addr[11:2]];
      end else begin
         mem_ack = 0; mem_rdata = $urandom;
         if (mem_req) wait_cnt++;
      end
      #1;
      cyc++;
      if (prev_ack) check("req_gap", {31'd0, mem_req}, 0);
      if (mem_req) begin
         if (!beat_active) begin
            beat_active = 1; hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
         end else begin
            check("hold_addr", mem_addr, hold_addr);
            check("hold_we", {31'd0, mem_we}, {31'd0, hold_we});
            check("hold_wdata", mem_wdata, hold_wdata);
         end
         if (mem_ack) begin
            if (nob < 32) begin
               ob_addr[nob] = mem_addr; ob_we[nob] = mem_we;
               ob_data[nob] = mem_we ? mem_wdata : mem_rdata;
            end
            nob++;
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            beat_active = 0; wait_cnt = 0; beat_no++;
         end
      end
      prev_ack = mem_req & mem_ack;
      if (rb_write_en) begin
         if (nwr < 32) begin ow_sel[nwr] = rb_write_select; ow_data[nwr] = rb_write_data; end
         nwr++;
      end
      pend_we = rb_write_en; pend_wsel = rb_write_select; pend_wdata = rb_write_data;
      pend_rsel = rb_read_select;
      done_seen = done;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_done"}, {31'd0, done}, 0);
      check({tag, "_req"}, {31'd0, mem_req}, 0);
      check({tag, "_we"}, {31'd0, mem_we}, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_wdata"}, mem_wdata, 0);
      check({tag, "_rsel"}, {28'd0, rb_read_select}, 0);
      check({tag, "_wen"}, {31'd0, rb_write_en}, 0);
      check({tag, "_wsel"}, {28'd0, rb_write_select}, 0);
      check({tag, "_wdat"}, rb_write_data, 0);
   endtask

   // mode: 0 zero-wait, 1 three wait cycles per beat, 2 random 0..2
   task automatic xfer(input logic ld, input logic u, input logic p, input logic w,
                       input logic [3:0] br, input logic [31:0] base, input logic [15:0] list,
                       input int mode);
      logic [31:0] ea [16], ed [16], ewd [17], lo;
      logic [3:0]  ews [17];
      int cnt, ne, nw, tot, lat;
      cnt = $countones(list); ne = 0; nw = 0; tot = 0;
      lo = u ? base + (p ? 32'd4 : 32'd0) : base - 32'(4 * cnt) + (p ? 32'd0 : 32'd4);
      for (int n = 0; n < 16; n++)
         if (list[n]) begin
            ea[ne] = lo + 32'(4 * ne);
            ed[ne] = ld ? mem[ea[ne][11:2]] : regs[n];
            if (ld) begin ews[nw] = 4'(n); ewd[nw] = ed[ne]; nw++; end
            ne++;
         end
`ifdef BLOCK_XFER_WRITEBACK_EN
      if (w && cnt > 0 && !(ld && list[br])) begin
         ews[nw] = br; ewd[nw] = u ? base + 32'(4 * cnt) : base - 32'(4 * cnt); nw++;
      end
`endif
      for (int k = 0; k < 16; k++) begin
         waits[k] = (mode == 0) ? 0 : (mode == 1) ? 3 : $urandom_range(0, 2);
         if (k < cnt) tot += waits[k];
      end
      lat = 2 + (ld ? 2 : 3) * cnt + (nw > (ld ? cnt : 0) ? 1 : 0) + tot;
      nob = 0; nwr = 0; cyc = 0; beat_no = 0; wait_cnt = 0; beat_active = 0;
      is_load = ld; up = u; pre = p; writeback = w; base_reg = br; base_addr = base;
      reg_list = list; start = 1;
      step();
      start = 0;
      while (!done_seen && cyc < 500) begin
         if (cyc >= 2) begin
            start = ($urandom_range(0, 3) == 0); reg_list = $urandom; base_addr = $urandom;
            is_load = $urandom; up = $urandom; pre = $urandom; writeback = $urandom;
            base_reg = $urandom;
         end
         step();
      end
      start = 0;
      check("done_lat", cyc, lat);
      check("nbeats", nob, ne);
      for (int k = 0; k < ne && k < nob; k++) begin
         check("beat_addr", ob_addr[k], ea[k]);
         check("beat_we", {31'd0, ob_we[k]}, {31'd0, ~ld});
         check("beat_data", ob_data[k], ed[k]);
      end
      check("nwrites", nwr, nw);
      for (int k = 0; k < nw && k < nwr; k++) begin
         check("wr_sel", {28'd0, ow_sel[k]}, {28'd0, ews[k]});
         check("wr_data", ow_data[k], ewd[k]);
      end
      step();
      check("busy_after", {31'd0, busy}, 0);
      check("done_after", {31'd0, done}, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int k = 0; k < 16; k++) waits[k] = 0;
      step(); step();
      check_idle("rst");
      reset_n = 1;
      step();
      regs[0] = 32'hA; regs[2] = 32'hB;
      xfer(0, 1, 0, 0, 4'd0, 32'h100, 16'h0005, 0);
      check("t1_m0", mem[32'h100 >> 2], 32'hA);
      check("t1_m1", mem[32'h104 >> 2], 32'hB);
      xfer(1, 0, 1, 1, 4'd13, 32'h200, 16'h8003, 0);
      xfer(0, 1, 1, 0, 4'd0, 32'h300, 16'h00F0, 1);
      xfer(1, 0, 0, 0, 4'd0, 32'h600, 16'h0A50, 1);
      xfer(0, 1, 0, 1, 4'd3, 32'h400, 16'h0000, 0);
      xfer(1, 0, 1, 1, 4'd3, 32'h400, 16'h0000, 0);
      xfer(1, 1, 0, 1, 4'd2, 32'h700, 16'h0004, 0);
      // reset while a beat is outstanding
      for (int k = 0; k < 16; k++) waits[k] = 10;
      is_load = 0; up = 1; pre = 0; writeback = 0; base_addr = 32'h500; reg_list = 16'h0003;
      start = 1; cyc = 0; beat_no = 0; wait_cnt = 0;
      step();
      start = 0;
      while (!mem_req && cyc < 20) step();
      check("rst_mid_req", {31'd0, mem_req}, 1);
      reset_n = 0;
      step();
      check_idle("rst_mid");
      reset_n = 1; beat_active = 0; prev_ack = 0;
      xfer(0, 1, 0, 0, 4'd0, 32'h500, 16'h0003, 0);
      for (int t = 0; t < 40; t++) begin
         logic [15:0] l;
         l = $urandom;
         if ($urandom_range(0, 7) == 0) l = 0;
         xfer($urandom, $urandom, $urandom, $urandom, 4'($urandom),
              32'h400 + (32'($urandom_range(0, 32'h1C0)) << 2), l, 2);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
